issue_select: RTL and testbench



---
 rtl/issue_select.sv | 111 +++++++++++
 tb/tb_issue_select.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_select.sv
// Age-ordered select arbiter: grants the single functional-unit issue port to the
// oldest eligible issue slot, and reports stall and starvation telemetry.
module issue_select #(
    parameter int NUM_SLOTS    = 8,
    parameter int IDX_W        = $clog2(NUM_SLOTS),
    parameter int STARVE_LIMIT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_alloc_valid,
    input  logic [IDX_W-1:0]     io_alloc_idx,
    input  logic [NUM_SLOTS-1:0] io_valid,
    input  logic [NUM_SLOTS-1:0] io_request,
    input  logic                 io_fu_ready,
    input  logic                 io_flush,
    output logic [NUM_SLOTS-1:0] io_grant,
    output logic                 io_grant_valid,
    output logic [IDX_W-1:0]     io_grant_idx,
    output logic [15:0]          io_stall_cycles,
    output logic                 io_starve
);

    // Handshake: a slot issues in the cycle where io_request & io_valid & io_grant is set;
    // io_fu_ready acts as the port's ready and no grant is ever offered without it.

    // older_q[i][j] = 1 means slot i was allocated before slot j
    logic [NUM_SLOTS-1:0] older_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] req_e;
    logic [NUM_SLOTS-1:0] blocked;
    logic [NUM_SLOTS-1:0] oldest;
    logic [IDX_W-1:0]     oldest_idx;
    logic                 any_req;
    logic                 grant_en;
    logic                 alloc_ok;
    logic [7:0]           starve_cnt_q;
    logic [IDX_W-1:0]     track_idx_q;
    logic                 track_valid_q;

    assign alloc_ok = io_alloc_valid && (int'(io_alloc_idx) < NUM_SLOTS);

    always_comb begin
        req_e      = io_request & io_valid;
        any_req    = |req_e;
        blocked    = '0;
        oldest     = '0;
        oldest_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (j != i && req_e[j] && older_q[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        // Descending scan so the lowest unblocked index is written last and wins ties.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (req_e[i] && !blocked[i]) begin
                oldest     = '0;
                oldest[i]  = 1'b1;
                oldest_idx = IDX_W'(i);
            end
        end
        grant_en       = io_fu_ready && !io_flush && reset;
        io_grant       = grant_en ? oldest : '0;
        io_grant_valid = |io_grant;
        io_grant_idx   = io_grant_valid ? oldest_idx : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset || io_flush) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                older_q[i] <= '0;
            end
        end else if (alloc_ok) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (j == int'(io_alloc_idx)) begin
                    older_q[j] <= '0;
                end else begin
                    older_q[j][io_alloc_idx] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            io_stall_cycles <= '0;
        end else if (any_req && !io_grant_valid && io_stall_cycles != 16'hFFFF) begin
            io_stall_cycles <= io_stall_cycles + 16'd1;
        end
    end

    // A change of the tracked oldest slot restarts the count; the first tracked cycle counts.
    always_ff @(posedge clk) begin
        if (!reset || io_flush || !any_req) begin
            starve_cnt_q  <= '0;
            track_idx_q   <= '0;
            track_valid_q <= 1'b0;
        end else begin
            track_idx_q   <= oldest_idx;
            track_valid_q <= 1'b1;
            if (io_grant_valid || (track_valid_q && track_idx_q != oldest_idx)) begin
                starve_cnt_q <= '0;
            end else if (starve_cnt_q != 8'hFF) begin
                starve_cnt_q <= starve_cnt_q + 8'd1;
            end
        end
    end

    assign io_starve = (int'(starve_cnt_q) >= STARVE_LIMIT);

endmodule

// File: tb/tb_issue_select.sv
// Self-checking bench for issue_select: directed vector table, corner sequences,
// and randomized traffic against an allocation-timestamp reference model.
module tb_issue_select;
    localparam int NS = 8;
    localparam int IW = 3;
    localparam int SL = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_alloc_valid;
    logic [IW-1:0] io_alloc_idx;
    logic [NS-1:0] io_valid;
    logic [NS-1:0] io_request;
    logic          io_fu_ready;
    logic          io_flush;
    logic [NS-1:0] io_grant;
    logic          io_grant_valid;
    logic [IW-1:0] io_grant_idx;
    logic [15:0]   io_stall_cycles;
    logic          io_starve;

    issue_select #(.NUM_SLOTS(NS), .IDX_W(IW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .io_alloc_valid(io_alloc_valid), .io_alloc_idx(io_alloc_idx),
        .io_valid(io_valid), .io_request(io_request),
        .io_fu_ready(io_fu_ready), .io_flush(io_flush),
        .io_grant(io_grant), .io_grant_valid(io_grant_valid), .io_grant_idx(io_grant_idx),
        .io_stall_cycles(io_stall_cycles), .io_starve(io_starve)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each slot carries the time it was last allocated (0 = never
    // since reset/flush); the oldest eligible slot has the smallest stamp, lowest index on ties.
    int unsigned stamp_m [NS];
    int unsigned now_m;
    int unsigned stall_m;
    int unsigned starve_m;
    int          track_m;
    bit          track_valid_m;

    typedef struct {
        bit          av;
        int          ai;
        logic [NS-1:0] val;
        logic [NS-1:0] req;
        bit          fu;
        bit          fl;
        int          exp_idx;
        bit          exp_gv;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_oldest(input logic [NS-1:0] re);
        int best = -1;
        for (int i = 0; i < NS; i++) begin
            if (re[i] && (best < 0 || stamp_m[i] < stamp_m[best])) best = i;
        end
        return best;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NS; i++) stamp_m[i] = 0;
        now_m = 0; stall_m = 0; starve_m = 0; track_m = 0; track_valid_m = 1'b0;
    endtask

    task automatic drive(input bit av, input int ai, input logic [NS-1:0] val,
                         input logic [NS-1:0] req, input bit fu, input bit fl);
        io_alloc_valid = av;
        io_alloc_idx   = IW'(ai);
        io_valid       = val;
        io_request     = req;
        io_fu_ready    = fu;
        io_flush       = fl;
    endtask

    // Compare every output against the model at the falling edge, then advance one clock.
    task automatic cycle();
        logic [NS-1:0] re;
        logic [NS-1:0] one;
        logic [NS-1:0] exp_grant;
        int  old;
        bit  gv;
        @(negedge clk);
        re  = io_request & io_valid;
        old = model_oldest(re);
        gv  = io_fu_ready && !io_flush && reset && (old >= 0);
        one = 1;
        exp_grant = gv ? (one << old) : '0;
        check("grant", 32'(io_grant), 32'(exp_grant));
        check("grant_valid", 32'(io_grant_valid), 32'(gv));
        check("grant_idx", 32'(io_grant_idx), gv ? 32'(old) : 32'd0);
        check("stall_cycles", 32'(io_stall_cycles), stall_m);
        check("starve", 32'(io_starve), 32'(starve_m >= SL));
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            if (re != 0 && !gv && stall_m < 65535) stall_m++;
            if (io_flush || re == 0) begin
                starve_m = 0; track_valid_m = 1'b0; track_m = 0;
            end else begin
                if (gv || (track_valid_m && track_m != old)) starve_m = 0;
                else if (starve_m < 255) starve_m++;
                track_m = old; track_valid_m = 1'b1;
            end
            if (io_flush) begin
                for (int i = 0; i < NS; i++) stamp_m[i] = 0;
            end else if (io_alloc_valid) begin
                now_m++;
                stamp_m[io_alloc_idx] = now_m;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] stall_snap;
        int unsigned blk_fu;
        logic [NS-1:0] blk_req;

        tbl[0] = '{0, 0, 8'hFF, 8'b0000_0110, 1, 0, 1, 1};
        tbl[1] = '{1, 5, 8'hFF, 8'b0000_0000, 1, 0, 0, 0};
        tbl[2] = '{1, 2, 8'hFF, 8'b0000_0000, 1, 0, 0, 0};
        tbl[3] = '{1, 7, 8'hFF, 8'b0000_0000, 1, 0, 0, 0};
        tbl[4] = '{0, 0, 8'hFF, 8'b1010_0100, 1, 0, 5, 1};
        tbl[5] = '{0, 0, 8'hFF, 8'b1000_0100, 1, 0, 2, 1};
        tbl[6] = '{0, 0, 8'hFF, 8'b1000_0000, 1, 0, 7, 1};
        tbl[7] = '{0, 0, 8'h00, 8'b0000_0001, 1, 0, 0, 0};

        // Initial reset with a live request: grant must stay low.
        reset = 1'b0;
        drive(0, 0, 8'hFF, 8'h03, 1, 0);
        @(posedge clk); @(posedge clk); #1;
        model_clear();
        check("reset_grant", 32'(io_grant), 32'd0);
        check("reset_stall", 32'(io_stall_cycles), 32'd0);
        check("reset_starve", 32'(io_starve), 32'd0);
        reset = 1'b1;

        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].av, tbl[k].ai, tbl[k].val, tbl[k].req, tbl[k].fu, tbl[k].fl);
            stall_snap = io_stall_cycles;
            #1;
            check("tbl_grant_valid", 32'(io_grant_valid), 32'(tbl[k].exp_gv));
            check("tbl_grant_idx", 32'(io_grant_idx), 32'(tbl[k].exp_idx));
            cycle();
            if (k == 7) check("tbl_invalid_stall", 32'(io_stall_cycles), 32'(stall_snap));
        end

        // Starvation: 3 older than 1, port held busy.
        do_reset();
        drive(1, 3, 8'hFF, 8'h00, 0, 0); cycle();
        drive(1, 1, 8'hFF, 8'h00, 0, 0); cycle();
        drive(0, 0, 8'hFF, 8'b0000_1010, 0, 0);
        for (int c = 1; c <= 40; c++) begin
            cycle();
            if (c == SL - 1) check("starve_before_limit", 32'(io_starve), 32'd0);
            if (c == SL) check("starve_at_limit", 32'(io_starve), 32'd1);
        end
        check("stall_40", 32'(io_stall_cycles), 32'd40);
        io_fu_ready = 1'b1; #1;
        check("starve_grant_idx", 32'(io_grant_idx), 32'd3);
        cycle();
        check("starve_falls", 32'(io_starve), 32'd0);
        // Long denial saturates the starvation counter without wrapping.
        io_fu_ready = 1'b0;
        for (int c = 0; c < 300; c++) cycle();
        check("starve_saturated", 32'(io_starve), 32'd1);
        io_fu_ready = 1'b1; cycle();
        check("starve_clear_after_sat", 32'(io_starve), 32'd0);

        // Flush together with alloc: flush wins, matrix ends cleared.
        drive(1, 4, 8'hFF, 8'h00, 1, 0); cycle();
        drive(1, 6, 8'hFF, 8'h00, 1, 0); cycle();
        drive(1, 6, 8'hFF, 8'h00, 1, 1); stall_snap = io_stall_cycles; cycle();
        drive(0, 0, 8'hFF, 8'b0101_0000, 1, 0); #1;
        check("flush_grant_idx", 32'(io_grant_idx), 32'd4);
        check("flush_stall_kept", 32'(io_stall_cycles), 32'(stall_snap));
        cycle();
        drive(1, 6, 8'hFF, 8'h00, 1, 0); cycle();
        drive(1, 4, 8'hFF, 8'h00, 1, 0); cycle();
        drive(1, 4, 8'hFF, 8'h00, 1, 1); cycle();
        drive(0, 0, 8'hFF, 8'b0101_0000, 1, 0); #1;
        check("flush_tie_idx", 32'(io_grant_idx), 32'd4);
        cycle();
        // Grant and alloc of the same slot: old age for this grant.
        drive(1, 6, 8'hFF, 8'h00, 1, 0); cycle();
        drive(1, 4, 8'hFF, 8'b0101_0000, 1, 0); #1;
        check("same_slot_alloc_grant", 32'(io_grant_idx), 32'd4);
        cycle();
        drive(0, 0, 8'hFF, 8'b0101_0000, 1, 0); #1;
        check("after_realloc_grant", 32'(io_grant_idx), 32'd6);
        cycle();

        // Reset asserted mid-stream with a request pending and the port busy.
        drive(0, 0, 8'hFF, 8'b0101_0000, 0, 0); cycle(); cycle();
        reset = 1'b0; io_fu_ready = 1'b1; #1;
        check("midreset_grant", 32'(io_grant), 32'd0);
        cycle();
        check("midreset_stall", 32'(io_stall_cycles), 32'd0);
        check("midreset_starve", 32'(io_starve), 32'd0);
        reset = 1'b1;

        // Random traffic in blocks alternating a mostly-ready and a mostly-busy port.
        for (int b = 0; b < 16; b++) begin
            blk_fu  = (b % 2 == 0) ? 90 : 4;
            blk_req = NS'($urandom);
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 99) < 8) blk_req = NS'($urandom);
                io_alloc_valid = ($urandom_range(0, 99) < ((b % 2 == 0) ? 50 : 10));
                io_alloc_idx   = IW'($urandom_range(0, NS - 1));
                io_valid       = ($urandom_range(0, 3) == 0) ? NS'($urandom) : 8'hFF;
                io_request     = (b % 2 == 0) ? NS'($urandom) : blk_req;
                io_fu_ready    = ($urandom_range(0, 99) < blk_fu);
                io_flush       = ($urandom_range(0, 99) < 3);
                reset          = !($urandom_range(0, 199) == 0);
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
